// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: mono sample to I2S serialiser with a one-word holding register.
// Define TX_MUTE_ON_UNDERRUN_EN to send silence on underrun instead of repeating the last word.
module i2s_sample_tx #(
  parameter int fxp_size  = 16,
  parameter int out_width = 16,
  parameter int slot_bits = 32,
  parameter int bclk_div  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [fxp_size-1:0] i_sample,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_bclk,
  output logic                       o_lrclk,
  output logic                       o_sdata,
  output logic                       o_underrun
);
  localparam int dw = $clog2(bclk_div);
  localparam int bw = $clog2(2 * slot_bits);
  localparam int kw = $clog2(slot_bits);
  logic [dw-1:0] div_cnt, div_nxt;
  logic [bw-1:0] bit_cnt, bit_nxt;
  logic [kw-1:0] k_nxt;
  logic [out_width-1:0] pending, tx_word, shreg, word;
  logic fe, bit_wrap, load, accept;
  assign word     = i_sample[fxp_size-1 -: out_width];
  assign fe       = div_cnt == dw'(bclk_div - 1);
  assign div_nxt  = fe ? '0 : div_cnt + dw'(1);
  assign bit_wrap = bit_cnt == bw'(2 * slot_bits - 1);
  assign bit_nxt  = bit_wrap ? '0 : bit_cnt + bw'(1);
  assign k_nxt    = bit_nxt >= bw'(slot_bits) ? kw'(bit_nxt - bw'(slot_bits)) : kw'(bit_nxt);
  assign load     = fe && bit_wrap;
  assign accept   = i_valid && o_ready;
  // o_ready doubles as the "holding register empty" flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      pending    <= '0;
      tx_word    <= '0;
      shreg      <= '0;
      o_ready    <= 1'b1;
      o_bclk     <= 1'b0;
      o_lrclk    <= 1'b0;
      o_sdata    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      o_bclk     <= div_nxt >= dw'(bclk_div / 2);
      o_underrun <= load && o_ready && !i_valid;
      if (fe) begin
        bit_cnt <= bit_nxt;
        o_lrclk <= bit_nxt >= bw'(slot_bits);
        o_sdata <= k_nxt == kw'(1) ? tx_word[out_width-1] :
                   (k_nxt > kw'(1) && k_nxt <= kw'(out_width)) ? shreg[out_width-1] : 1'b0;
        shreg   <= k_nxt == kw'(1) ? tx_word << 1 : shreg << 1;
      end
      if (load && !o_ready) begin
        tx_word <= pending;
        o_ready <= 1'b1;
      end else if (load && i_valid) begin
        tx_word <= word;
`ifdef TX_MUTE_ON_UNDERRUN_EN
      end else if (load) begin
        tx_word <= '0;
`else
`endif
      end else if (accept) begin
        pending <= word;
        o_ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: directed frame table plus random traffic against a frame-level I2S model.
module tb_i2s_sample_tx;
  localparam int fw = 16, ow = 16, sb = 32, bd = 4, fr = 2 * sb * bd;
`ifdef TX_MUTE_ON_UNDERRUN_EN
  localparam logic [ow-1:0] rep_word = 16'h0000;
`else
  localparam logic [ow-1:0] rep_word = 16'h1234;
`endif
  typedef struct {
    logic [fw-1:0] s1;
    int            o1;
    logic [fw-1:0] s2;
    int            o2;
    logic [ow-1:0] exp;
    int            und;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0;
  logic [fw-1:0] i_sample = '0;
  logic o_ready, o_bclk, o_lrclk, o_sdata, o_underrun;
  int checks = 0, errors = 0;
  int n = 0, und_cnt = 0;
  logic [ow-1:0] cur = '0, rl = '0, rr = '0, last_l = '0, last_r = '0;
  logic [ow-1:0] pend[$];
  logic m_und = 1'b0;
  always #5 clk = ~clk;
  i2s_sample_tx #(.fxp_size(fw), .out_width(ow), .slot_bits(sb), .bclk_div(bd)) dut (
    .clk(clk), .rst(rst), .i_sample(i_sample), .i_valid(i_valid), .o_ready(o_ready),
    .o_bclk(o_bclk), .o_lrclk(o_lrclk), .o_sdata(o_sdata), .o_underrun(o_underrun)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, n);
    end
  endtask
  // one clock: model the frame/handshake rules, then compare every output
  task automatic step(input logic v, input logic [fw-1:0] s);
    logic [ow-1:0] w;
    int k, kk;
    i_valid = v;
    i_sample = s;
    w = s[fw-1 -: ow];
    @(posedge clk);
    m_und = 1'b0;
    if ((n + 1) % fr == 0) begin
      if (pend.size() != 0) cur = pend.pop_front();
      else if (v) cur = w;
      else begin
        m_und = 1'b1;
`ifdef TX_MUTE_ON_UNDERRUN_EN
        cur = '0;
`endif
      end
    end else if (v && pend.size() == 0) pend.push_back(w);
    n++;
    #1;
    kk = (n / bd) % (2 * sb);
    k = kk % sb;
    chk("outputs{bclk,lrclk,sdata,ready,underrun}", {o_bclk, o_lrclk, o_sdata, o_ready, o_underrun},
        {(n % bd) >= bd / 2, kk >= sb, (k >= 1 && k <= ow) ? cur[ow-k] : 1'b0, pend.size() == 0, m_und});
    und_cnt += int'(o_underrun);
    if (n % bd == bd / 2 && k >= 1 && k <= ow) begin
      if (kk < sb) rl[ow-k] = o_sdata;
      else rr[ow-k] = o_sdata;
    end
    if (n % fr == fr - 1) begin
      last_l = rl;
      last_r = rr;
    end
  endtask
  task automatic run_frame(input vec_t t);
    logic v;
    for (int off = 0; off < fr; off++) begin
      v = (off == t.o1) || (off == t.o2);
      step(v, v ? (off == t.o1 ? t.s1 : t.s2) : fw'($urandom));
    end
  endtask
  task automatic check_frame(input string nm, input logic [ow-1:0] exp, input int und);
    chk({nm, "_left"}, 32'(last_l), 32'(exp));
    chk({nm, "_right"}, 32'(last_r), 32'(exp));
    chk({nm, "_underrun_pulses"}, und_cnt, und);
  endtask
  initial begin
    vec_t tab[8];
    vec_t idle;
    logic [ow-1:0] prev;
    tab[0] = '{16'hA5C3, 10, 16'h0000, -1, 16'hA5C3, 0};
    tab[1] = '{16'h1234, 20, 16'hFFFF, 40, 16'h1234, 0};
    tab[2] = '{16'h0000, -1, 16'h0000, -1, rep_word, 1};
    tab[3] = '{16'hFFFF, 30, 16'h0000, -1, 16'hFFFF, 0};
    tab[4] = '{16'h8001, fr - 1, 16'h0000, -1, 16'h8001, 0};
    tab[5] = '{16'h0000, 100, 16'h0000, -1, 16'h0000, 0};
    tab[6] = '{16'h7FFF, 200, 16'h0000, -1, 16'h7FFF, 0};
    tab[7] = '{16'hC0DE, 0, 16'hBEEF, 1, 16'hC0DE, 0};
    idle = '{16'h0000, -1, 16'h0000, -1, 16'h0000, 1};
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'($urandom);
      i_sample = fw'($urandom);
      @(posedge clk);
      #1;
      chk("reset_hold", {o_bclk, o_lrclk, o_sdata, o_ready, o_underrun}, 5'b00010);
    end
    i_valid = 1'b0;
    rst = 1'b1;
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      und_cnt = 0;
      run_frame(tab[i]);
      check_frame("table_frame", prev, tab[i].und);
      prev = tab[i].exp;
    end
    und_cnt = 0;
    run_frame('{16'h5A5A, 0, 16'h0000, -1, 16'h0000, 0});
    check_frame("last_table_frame", prev, 0);
    for (int i = 0; i < 42; i++) step(1'b0, fw'($urandom));
    #2 rst = 1'b0;
    #1 chk("reset_mid_word", {o_bclk, o_lrclk, o_sdata, o_ready, o_underrun}, 5'b00010);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_mid_hold", {o_bclk, o_lrclk, o_sdata, o_ready, o_underrun}, 5'b00010);
    end
    rst = 1'b1;
    n = 0;
    cur = '0;
    pend.delete();
    und_cnt = 0;
    run_frame(idle);
    check_frame("post_reset_frame0", 16'h0000, 1);
    und_cnt = 0;
    run_frame(idle);
    check_frame("post_reset_frame1", 16'h0000, 1);
    for (int f = 0; f < 20; f++) begin
      for (int off = 0; off < fr; off++)
        step(($urandom_range(0, 199) == 0) || (off == fr - 1 && $urandom_range(0, 3) == 0), fw'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
